// File: rtl/reaction_display_scan.sv
// Binary-to-BCD display path: sequential double-dabble conversion with a load/busy
// handshake, committed digit hold, and a time-multiplexed 7-segment scan.
module reaction_display_scan #(
  parameter int unsigned IN_WIDTH   = 14,
  parameter int unsigned NUM_DIGITS = 4,
  parameter int unsigned SCAN_DIV   = 1000,
  parameter int unsigned BLANK_LZ   = 1
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic [IN_WIDTH-1:0]   value,
  input  logic                  load,
  output logic                  busy,
  output logic                  overflow,
  output logic [6:0]            seg,
  output logic [NUM_DIGITS-1:0] an
);

  localparam int unsigned BW   = 4 * NUM_DIGITS;
  localparam int unsigned SCW  = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
  localparam int unsigned IW   = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;
  localparam int unsigned CNTW = $clog2(IN_WIDTH + 1);
  localparam int unsigned PW   = IN_WIDTH + 5;

  // Smallest value that no longer fits in NUM_DIGITS decimal digits, saturated at 2^IN_WIDTH
  // so that an input range too narrow to overflow never flags.
  function automatic logic [PW-1:0] ovf_limit();
    logic [PW-1:0] p;
    p = PW'(1);
    for (int i = 0; i < int'(NUM_DIGITS); i++) begin
      p = p * PW'(10);
      if (p > (PW'(1) << IN_WIDTH)) p = PW'(1) << IN_WIDTH;
    end
    return p;
  endfunction

  localparam logic [PW-1:0] OVF_LIM = ovf_limit();

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    SHIFT  = 2'd1,
    COMMIT = 2'd2
  } state_t;

  state_t              state_q;
  state_t              state_d;
  logic                start_c;
  logic                shift_c;
  logic                commit_c;

  logic [IN_WIDTH-1:0] sh;
  logic [BW-1:0]       bcd;
  logic [BW-1:0]       bcd_next_c;
  logic [CNTW-1:0]     bit_cnt;
  logic                ovf_pend;
  logic [BW-1:0]       disp;

  logic [SCW-1:0]        scan_cnt;
  logic [IW-1:0]         idx;
  logic [NUM_DIGITS-1:0] lz_c;
  logic [3:0]            cur_c;
  logic                  blank_c;
  logic [6:0]            seg_c;
  logic [NUM_DIGITS-1:0] an_c;

  // Conversion FSM: state register
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= IDLE;
      busy    <= 1'b0;
    end else begin
      state_q <= state_d;
      busy    <= (state_d != IDLE);
    end
  end

  // Conversion FSM: next state and datapath strobes
  always_comb begin
    state_d  = state_q;
    start_c  = 1'b0;
    shift_c  = 1'b0;
    commit_c = 1'b0;
    case (state_q)
      IDLE: begin
        if (load) begin
          start_c = 1'b1;
          state_d = SHIFT;
        end
      end
      SHIFT: begin
        shift_c = 1'b1;
        if (bit_cnt == CNTW'(IN_WIDTH - 1)) state_d = COMMIT;
      end
      COMMIT: begin
        commit_c = 1'b1;
        state_d  = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  // One double-dabble step: add-3 on nibbles >= 5, then shift in the next input MSB.
  // The carry out of the top nibble is dropped; such values are flagged by ovf_pend.
  always_comb begin
    logic [3:0] nib;
    logic       cin;
    bcd_next_c = '0;
    cin        = sh[IN_WIDTH-1];
    for (int i = 0; i < int'(NUM_DIGITS); i++) begin
      nib = bcd[4*i +: 4];
      if (nib >= 4'd5) nib = nib + 4'd3;
      bcd_next_c[4*i +: 4] = {nib[2:0], cin};
      cin = nib[3];
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      sh       <= '0;
      bcd      <= '0;
      bit_cnt  <= '0;
      ovf_pend <= 1'b0;
      disp     <= '0;
      overflow <= 1'b0;
    end else begin
      if (start_c) begin
        sh       <= value;
        bcd      <= '0;
        bit_cnt  <= '0;
        ovf_pend <= (PW'(value) >= OVF_LIM);
      end
      if (shift_c) begin
        sh      <= sh << 1;
        bcd     <= bcd_next_c;
        bit_cnt <= bit_cnt + CNTW'(1);
      end
      if (commit_c) begin
        disp     <= bcd;
        overflow <= ovf_pend;
      end
    end
  end

  // Digit scan timebase, free-running and independent of conversion
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      scan_cnt <= '0;
      idx      <= '0;
    end else if (scan_cnt == SCW'(SCAN_DIV - 1)) begin
      scan_cnt <= '0;
      idx      <= (idx == IW'(NUM_DIGITS - 1)) ? '0 : idx + IW'(1);
    end else begin
      scan_cnt <= scan_cnt + SCW'(1);
    end
  end

  // lz_c[i]: digits i..NUM_DIGITS-1 are all zero
  always_comb begin
    logic run;
    run  = 1'b1;
    lz_c = '0;
    for (int i = int'(NUM_DIGITS) - 1; i >= 0; i--) begin
      run     = run & (disp[4*i +: 4] == 4'd0);
      lz_c[i] = run;
    end
  end

  always_comb begin
    cur_c   = 4'd0;
    blank_c = 1'b0;
    for (int i = 0; i < int'(NUM_DIGITS); i++) begin
      if (idx == IW'(i)) begin
        cur_c   = disp[4*i +: 4];
        blank_c = lz_c[i] && (i != 0);
      end
    end
  end

  // Segment pattern, overflow dash taking priority over blanking
  always_comb begin
    case (cur_c)
      4'd0:    seg_c = 7'h3F;
      4'd1:    seg_c = 7'h06;
      4'd2:    seg_c = 7'h5B;
      4'd3:    seg_c = 7'h4F;
      4'd4:    seg_c = 7'h66;
      4'd5:    seg_c = 7'h6D;
      4'd6:    seg_c = 7'h7D;
      4'd7:    seg_c = 7'h07;
      4'd8:    seg_c = 7'h7F;
      4'd9:    seg_c = 7'h6F;
      default: seg_c = 7'h00;
    endcase
    if ((BLANK_LZ != 0) && blank_c) seg_c = 7'h00;
    if (overflow) seg_c = 7'h40;
    an_c = NUM_DIGITS'(1) << idx;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      seg <= 7'h00;
      an  <= '0;
    end else begin
      seg <= seg_c;
      an  <= an_c;
    end
  end

endmodule

// File: tb/tb_reaction_display_scan.sv
// Bench for reaction_display_scan: three instances (blanking on/off, fast scan) driven
// in lockstep and compared every cycle against an arithmetic reference model.
module tb_reaction_display_scan;

  logic        clk;
  logic        reset;
  logic [13:0] value;
  logic        load;

  logic       busy_a, busy_b, busy_c;
  logic       ovf_a, ovf_b, ovf_c;
  logic [6:0] seg_a, seg_b, seg_c;
  logic [3:0] an_a, an_b, an_c;

  int n_checks = 0;
  int n_errors = 0;

  reaction_display_scan #(.IN_WIDTH(14), .NUM_DIGITS(4), .SCAN_DIV(4), .BLANK_LZ(1)) dut_a (
    .clk(clk), .reset(reset), .value(value), .load(load),
    .busy(busy_a), .overflow(ovf_a), .seg(seg_a), .an(an_a));

  reaction_display_scan #(.IN_WIDTH(14), .NUM_DIGITS(4), .SCAN_DIV(4), .BLANK_LZ(0)) dut_b (
    .clk(clk), .reset(reset), .value(value), .load(load),
    .busy(busy_b), .overflow(ovf_b), .seg(seg_b), .an(an_b));

  reaction_display_scan #(.IN_WIDTH(14), .NUM_DIGITS(4), .SCAN_DIV(1), .BLANK_LZ(1)) dut_c (
    .clk(clk), .reset(reset), .value(value), .load(load),
    .busy(busy_c), .overflow(ovf_c), .seg(seg_c), .an(an_c));

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  function automatic logic [6:0] exp_seg_f(input int unsigned val, input int d,
                                           input bit blank, input bit ovf);
    int unsigned p;
    p = 1;
    for (int i = 0; i < d; i++) p = p * 10;
    if (ovf) return 7'h40;
    if (blank && d != 0 && val < p) return 7'h00;
    case ((val / p) % 10)
      0: return 7'h3F;
      1: return 7'h06;
      2: return 7'h5B;
      3: return 7'h4F;
      4: return 7'h66;
      5: return 7'h6D;
      6: return 7'h7D;
      7: return 7'h07;
      8: return 7'h7F;
      default: return 7'h6F;
    endcase
  endfunction

  // Reference model: busy lasts 15 cycles after an accepted load, the display takes the
  // value when busy ends, and the output shown after edge e is digit ((e-1)/SCAN_DIV)%4
  // of the display as it stood before that edge.
  int unsigned sd[3] = '{4, 4, 1};
  bit          bl[3] = '{1'b1, 1'b0, 1'b1};
  int unsigned m_edges = 0, m_disp = 0, m_pend = 0, m_bcnt = 0;
  bit          m_ovf = 1'b0;
  logic [3:0]  e_an[3]  = '{4'h0, 4'h0, 4'h0};
  logic [6:0]  e_seg[3] = '{7'h00, 7'h00, 7'h00};

  initial begin
    forever begin
      @(posedge clk or posedge reset);
      if (reset) begin
        m_edges = 0;
        m_disp  = 0;
        m_ovf   = 1'b0;
        m_bcnt  = 0;
        for (int k = 0; k < 3; k++) begin
          e_an[k]  = 4'h0;
          e_seg[k] = 7'h00;
        end
      end else begin
        m_edges++;
        for (int k = 0; k < 3; k++) begin
          int idx;
          idx      = int'(((m_edges - 1) / sd[k]) % 4);
          e_an[k]  = 4'(1 << idx);
          e_seg[k] = exp_seg_f(m_disp, idx, bl[k], m_ovf);
        end
        if (m_bcnt != 0) begin
          m_bcnt--;
          if (m_bcnt == 0) begin
            m_disp = m_pend;
            m_ovf  = (m_pend > 9999);
          end
        end else if (load) begin
          m_pend = value;
          m_bcnt = 15;
        end
      end
    end
  end

  initial begin
    forever begin
      @(negedge clk);
      check("busy_a", 32'(busy_a), 32'(m_bcnt != 0));
      check("busy_b", 32'(busy_b), 32'(m_bcnt != 0));
      check("busy_c", 32'(busy_c), 32'(m_bcnt != 0));
      check("ovf_a",  32'(ovf_a),  32'(m_ovf));
      check("ovf_c",  32'(ovf_c),  32'(m_ovf));
      check("an_a",   32'(an_a),   32'(e_an[0]));
      check("seg_a",  32'(seg_a),  32'(e_seg[0]));
      check("an_b",   32'(an_b),   32'(e_an[1]));
      check("seg_b",  32'(seg_b),  32'(e_seg[1]));
      check("an_c",   32'(an_c),   32'(e_an[2]));
      check("seg_c",  32'(seg_c),  32'(e_seg[2]));
    end
  end

  task automatic tick(input int n);
    repeat (n) begin
      @(posedge clk);
      #2;
    end
  endtask

  task automatic pulse_load(input int unsigned v);
    value = 14'(v);
    load  = 1'b1;
    tick(1);
    load  = 1'b0;
  endtask

  initial begin
    int n_busy;
    reset = 1'b1;
    load  = 1'b0;
    value = '0;
    tick(3);
    reset = 1'b0;
    tick(10);

    // Reset in the middle of a conversion discards it
    pulse_load(1234);
    tick(5);
    reset = 1'b1;
    tick(2);
    reset = 1'b0;
    tick(30);

    // Busy window length after an accepted load
    pulse_load(123);
    n_busy = 0;
    for (int i = 0; i < 40; i++) begin
      @(negedge clk);
      if (busy_a) n_busy++;
      else if (n_busy != 0) break;
    end
    check("busy_len", 32'(n_busy), 32'd15);
    tick(20);

    pulse_load(9999);
    tick(25);
    pulse_load(10000);
    tick(25);
    check("ovf_10000", 32'(ovf_a), 32'd1);
    pulse_load(5);
    tick(25);
    check("ovf_clear", 32'(ovf_a), 32'd0);
    pulse_load(0);
    tick(25);

    // Load while busy is dropped; the next one after busy falls is taken
    pulse_load(42);
    tick(4);
    pulse_load(77);
    tick(10);
    pulse_load(77);
    tick(25);

    pulse_load(807);
    tick(25);
    pulse_load(16383);
    tick(25);

    for (int i = 0; i < 600; i++) begin
      int unsigned r;
      r = $urandom_range(0, 3);
      case (r)
        0:       value = 14'($urandom_range(0, 9));
        1:       value = 14'($urandom_range(0, 999));
        2:       value = 14'($urandom_range(0, 9999));
        default: value = 14'($urandom_range(0, 16383));
      endcase
      load = ($urandom_range(0, 5) == 0);
      tick(1);
    end
    load = 1'b0;
    tick(25);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
